// File: rtl/simd_shift_sequencer.sv
// Multi-cycle shift controller that steps a 16-bit accumulator through an external single-step SIMD shifter.
// Optional arithmetic right shift per lane is enabled by defining SIMD_SEQ_ARITH_EN.
module simd_shift_sequencer #(
    parameter bit          ZERO_FAST = 1'b1,
    parameter int unsigned CNT_W     = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic [1:0]  in_mode,
    input  logic        in_left,
    input  logic [3:0]  in_amount,
`ifdef SIMD_SEQ_ARITH_EN
    input  logic        in_arith,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        busy,
    output logic [15:0] sh_input,
    output logic        sh_H,
    output logic        sh_O,
    output logic        sh_Q,
    output logic        sh_left,
    input  logic [15:0] sh_output
);

    localparam int unsigned DW = 16;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state;
    logic [DW-1:0]      acc;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         mode_r;
    logic               left_r;
    logic               arith_r;

    logic [CNT_W-1:0]   lane_w;
    logic [CNT_W-1:0]   amt_ext;
    logic [CNT_W-1:0]   eff;
    logic               fast;
    logic               arith_right_in;
    logic [DW-1:0]      msb_mask;
    logic [DW-1:0]      step;

`ifdef SIMD_SEQ_ARITH_EN
    assign arith_right_in = in_arith & ~in_left;
`else
    assign arith_right_in = 1'b0;
`endif

    // Lane width of the incoming request and its amount clamped to that width
    always_comb begin
        lane_w = CNT_W'(16);
        case (in_mode)
            2'b00:   lane_w = CNT_W'(4);
            2'b01:   lane_w = CNT_W'(8);
            default: lane_w = CNT_W'(16);
        endcase
        amt_ext = CNT_W'(in_amount);
        eff     = (amt_ext > lane_w) ? lane_w : amt_ext;
        fast    = ZERO_FAST && (eff == lane_w) && !arith_right_in;
    end

    // Sign bits of each lane; OR-ing them back in turns a logical right step into an arithmetic one
    always_comb begin
        msb_mask = 16'h8000;
        case (mode_r)
            2'b00:   msb_mask = 16'h8888;
            2'b01:   msb_mask = 16'h8080;
            default: msb_mask = 16'h8000;
        endcase
        step = sh_output;
        if (arith_r && !left_r) begin
            step = sh_output | (acc & msb_mask);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            mode_r    <= 2'b00;
            left_r    <= 1'b0;
            arith_r   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        acc      <= fast ? '0 : in_data;
                        mode_r   <= in_mode;
                        left_r   <= in_left;
                        arith_r  <= arith_right_in;
                        cnt      <= eff;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (eff == '0 || fast) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    acc <= step;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // Return through IDLE so a new request is never taken on the result handshake edge
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign out_data = acc;
    assign sh_input = acc;
    assign sh_Q     = (mode_r == 2'b00);
    assign sh_O     = (mode_r == 2'b01);
    assign sh_H     = mode_r[1];
    assign sh_left  = left_r;

endmodule

// File: tb/tb_simd_shift_sequencer.sv
// Scoreboard bench for simd_shift_sequencer: the bench also plays the single-step lane shifter.
module tb_simd_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_mode;
    logic        in_left;
    logic [3:0]  in_amount;
    logic        in_arith;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        busy;
    logic [15:0] sh_input;
    logic        sh_H, sh_O, sh_Q;
    logic        sh_left;
    logic [15:0] sh_output;

    simd_shift_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_left   (in_left),
        .in_amount (in_amount),
`ifdef SIMD_SEQ_ARITH_EN
        .in_arith  (in_arith),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .sh_input  (sh_input),
        .sh_H      (sh_H),
        .sh_O      (sh_O),
        .sh_Q      (sh_Q),
        .sh_left   (sh_left),
        .sh_output (sh_output)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] data;
        int          rise;
    } exp_t;
    exp_t exp_q[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Shift every lane of x by amt; lanes never exchange bits
    function automatic logic [15:0] lane_shift(input logic [15:0] x, input int w, input bit left,
                                               input int amt, input bit arith);
        logic [15:0] r;
        int mask, v;
        r    = '0;
        mask = (1 << w) - 1;
        for (int base = 0; base < 16; base += w) begin
            v = (int'(x) >> base) & mask;
            if (left)
                v = (v << amt) & mask;
            else if (arith && (((v >> (w - 1)) & 1) == 1))
                v = ((v | ~mask) >>> amt) & mask;
            else
                v = v >> amt;
            r = r | 16'(v << base);
        end
        return r;
    endfunction

    function automatic int mode_w(input logic [1:0] m);
        return (m == 2'b00) ? 4 : (m == 2'b01) ? 8 : 16;
    endfunction

    // External single-step shifter
    always_comb begin
        sh_output = lane_shift(sh_input, sh_Q ? 4 : (sh_O ? 8 : 16), sh_left, 1, 1'b0);
    end

    task automatic send(input logic [15:0] d, input logic [1:0] m, input bit l, input logic [3:0] a,
                        input bit ar, input bit use_exp, input logic [15:0] xd, input int xlat,
                        output int acc_cyc);
        int   w, e, lat;
        bit   ar_eff, fast;
        exp_t item;
`ifdef SIMD_SEQ_ARITH_EN
        ar_eff = ar && !l;
`else
        ar_eff = 1'b0;
`endif
        w    = mode_w(m);
        e    = (int'(a) < w) ? int'(a) : w;
        fast = (e == w) && !ar_eff;
        lat  = (e == 0 || fast) ? 1 : e + 1;
        item.data = lane_shift(d, w, l, e, ar_eff);
        if (use_exp) begin
            item.data = xd;
            lat       = xlat;
        end
        in_valid  = 1'b1;
        in_data   = d;
        in_mode   = m;
        in_left   = l;
        in_amount = a;
        in_arith  = ar;
        acc_cyc   = -1;
        for (int t = 0; t < 200; t++) begin
            if (in_ready) begin
                acc_cyc = cyc + 1;
                break;
            end
            @(negedge clk);
        end
        if (acc_cyc < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
        end else begin
            item.rise = cyc + lat;
            exp_q.push_back(item);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Monitor: pops the scoreboard when a result appears and applies backpressure
    int          stall       = 0;
    int          stall_max   = 0;
    bit          force_stall = 1'b0;
    bit          prev_ov     = 1'b0;
    bit          hs_seen     = 1'b0;
    logic [15:0] held;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov   = 1'b0;
            hs_seen   = 1'b0;
            stall     = 0;
            out_ready = 1'b1;
        end else begin
            if (hs_seen) begin
                chk("out_valid_drop", 32'(out_valid), 32'd0);
                hs_seen = 1'b0;
            end
            if (out_valid) begin
                if (!prev_ov) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("out_data", 32'(out_data), 32'(mon_e.data));
                        chk("latency_cycle", 32'(cyc), 32'(mon_e.rise));
                    end
                    held        = out_data;
                    stall       = force_stall ? 3 : $urandom_range(0, stall_max);
                    force_stall = 1'b0;
                end else begin
                    chk("hold_data", 32'(out_data), 32'(held));
                    chk("hold_in_ready", 32'(in_ready), 32'd0);
                    chk("hold_busy", 32'(busy), 32'd1);
                    if (stall > 0) stall--;
                end
                out_ready = (stall == 0);
                if (out_ready) hs_seen = 1'b1;
            end else begin
                out_ready = 1'b1;
            end
            prev_ov = out_valid;
        end
    end

    int ca, cb, cc;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = '0;
        in_left   = 1'b0;
        in_amount = '0;
        in_arith  = 1'b0;
        #12;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_sh_sel",    32'({sh_H, sh_O, sh_Q}), 32'b001);
        chk("rst_sh_left",   32'(sh_left),   32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Directed cases with hand-derived results; first result is held off for 3 cycles
        force_stall = 1'b1;
        send(16'h1234, 2'b00, 1'b1, 4'd1,  1'b0, 1'b1, 16'h2468, 2,  ca);
        send(16'h80F0, 2'b01, 1'b0, 4'd3,  1'b0, 1'b1, 16'h101E, 4,  ca);
        send(16'h0001, 2'b10, 1'b1, 4'd15, 1'b0, 1'b1, 16'h8000, 16, ca);
        send(16'hBEEF, 2'b10, 1'b0, 4'd0,  1'b0, 1'b1, 16'hBEEF, 1,  ca);
        send(16'hFFFF, 2'b00, 1'b1, 4'd9,  1'b0, 1'b1, 16'h0000, 1,  ca);
        send(16'hF000, 2'b11, 1'b0, 4'd4,  1'b0, 1'b1, 16'h0F00, 5,  ca);
        send(16'hFFFF, 2'b01, 1'b0, 4'd8,  1'b0, 1'b1, 16'h0000, 1,  ca);
`ifdef SIMD_SEQ_ARITH_EN
        send(16'h8040, 2'b01, 1'b0, 4'd2,  1'b1, 1'b1, 16'hE010, 3,  ca);
        send(16'h8F00, 2'b00, 1'b0, 4'd4,  1'b1, 1'b1, 16'hFF00, 5,  ca);
`endif

        // Back-to-back requests with out_ready high: one accept every E+2 cycles
        send(16'h1357, 2'b00, 1'b1, 4'd3, 1'b0, 1'b0, 16'h0, 0, ca);
        send(16'h2468, 2'b00, 1'b1, 4'd3, 1'b0, 1'b0, 16'h0, 0, cb);
        send(16'h9ABC, 2'b00, 1'b0, 4'd3, 1'b0, 1'b0, 16'h0, 0, cc);
        chk("throughput", 32'(cc - cb), 32'd5);

        // Randomized traffic against the lane model, with random backpressure
        stall_max = 2;
        for (int i = 0; i < 80; i++) begin
            send(16'($urandom), 2'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
                 1'b0, 16'h0, 0, ca);
        end

        for (int t = 0; t < 400 && (exp_q.size() != 0 || out_valid); t++) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of a long shift discards the result
        stall_max = 0;
        send(16'h0001, 2'b10, 1'b1, 4'd15, 1'b0, 1'b0, 16'h0, 0, ca);
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_in_ready",  32'(in_ready),  32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_busy",      32'(busy),      32'd0);
        chk("arst_out_data",  32'(out_data),  32'd0);
        chk("arst_sh_sel",    32'({sh_H, sh_O, sh_Q}), 32'b001);
        chk("arst_sh_left",   32'(sh_left),   32'd0);
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_out_after_reset", 32'(out_valid), 32'd0);
        chk("idle_after_reset",   32'(in_ready),  32'd1);

        // Sequencer still works after the reset
        send(16'h00FF, 2'b01, 1'b1, 4'd4, 1'b0, 1'b1, 16'h00F0, 5, ca);
        for (int t = 0; t < 100 && (exp_q.size() != 0 || out_valid); t++) @(negedge clk);
        chk("final_drain", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/simd_shift_sequencer.md
Name: simd_shift_sequencer

Overview:
- Multi-bit shift controller placed directly upstream of the 16-bit single-step SIMD shifter.
- Accepts an operand, lane mode, direction and shift amount over a valid/ready handshake.
- Feeds its accumulator to the shifter and re-registers the shifter result once per cycle until the amount is exhausted, then presents the result on a valid/ready output.
- Lane modes: Q = four 4-bit lanes, O = two 8-bit lanes, H = one 16-bit lane.

Parameters:
- ZERO_FAST, 1: when 1, an effective amount equal to the lane width produces 16'h0000 without iterating.
- CNT_W, 5: width of the internal step counter. Must hold 16.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  sequencer can accept a request
- in_data  input  16  operand
- in_mode  input  2  00 = Q (4-bit lanes), 01 = O (8-bit lanes), 10 = H (16-bit), 11 = treated as H
- in_left  input  1  1 = left shift, 0 = logical right shift
- in_amount  input  4  shift amount, 0..15
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  16  shifted result
- busy  output  1  state is not IDLE
- sh_input  output  16  to shifter data input; equals the accumulator
- sh_H, sh_O, sh_Q  output  1 each  one-hot lane select decoded from the registered mode
- sh_left  output  1  registered direction to the shifter
- sh_output  input  16  single-step result from the shifter (combinational path)

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- State on reset:
  - state = IDLE.
  - acc = 0, cnt = 0, mode_r = 00, left_r = 0.
  - Outputs: in_ready = 1, out_valid = 0, busy = 0, out_data = 0, sh_Q = 1, sh_H = sh_O = 0, sh_left = 0.
- Lane width: W = 4, 8 or 16 from the mode. Effective amount E = min(in_amount, W).
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: acc <= in_data, mode_r <= in_mode, left_r <= in_left, cnt <= E.
  - Next state: DONE if E == 0, or if ZERO_FAST = 1 and E == W. In the ZERO_FAST case acc <= 0 instead of in_data. Otherwise SHIFT.
- SHIFT:
  - Each cycle: acc <= sh_output, cnt <= cnt - 1.
  - When cnt == 1, go to DONE.
  - Accepts no new request; in_ready = 0.
- DONE:
  - out_valid = 1 and out_data = acc.
  - acc is held stable while out_ready = 0.
  - On out_ready, go to IDLE and deassert out_valid the next cycle.
- Latency: out_valid rises E+1 cycles after the accept edge, or 1 cycle after on the zero/fast path.
- Throughput: one request per E+2 cycles with out_ready tied high. in_ready is not asserted in the same cycle as the DONE handshake.
- Request during SHIFT or DONE: ignored. The producer must hold it until in_ready.
- in_mode 11 behaves exactly like 10.
- Reset asserted mid-SHIFT or in DONE: immediate return to the reset state; the pending result is discarded and no out_valid is produced.
- Lane isolation is the shifter's job. The sequencer never modifies sh_output, except under the optional feature.

Optional Feature:
- Macro: SIMD_SEQ_ARITH_EN.
- When defined:
  - Adds port in_arith (input, 1) and an internal flag arith_r, captured on accept.
  - In SHIFT with arith_r = 1 and left_r = 0: acc <= sh_output | (acc & M). M is the per-lane MSB mask: Q 16'h8888, O 16'h8080, H 16'h8000. This gives an arithmetic right shift that sign-fills each lane.
  - The ZERO_FAST path is skipped for arithmetic right shifts; they always iterate.
- When undefined: no in_arith port; all right shifts are logical.

Test Plan:
- Q mode, left, amount 1, in_data 16'h1234: out_data 16'h2468, out_valid 2 cycles after accept.
- O mode, right, amount 3, in_data 16'h80F0: out_data 16'h101E, out_valid 4 cycles after accept.
- H mode, left, amount 15, in_data 16'h0001: out_data 16'h8000 after 16 cycles.
- H mode, amount 0, in_data 16'hBEEF: out_data 16'hBEEF 1 cycle after accept.
- Q mode, amount 9, in_data 16'hFFFF:
  - ZERO_FAST = 1: out_data 16'h0000, 1 cycle after accept.
  - ZERO_FAST = 0: out_data 16'h0000, 5 cycles after accept.
- out_ready low for 3 cycles in DONE: out_data stays stable, in_ready = 0, a held in_valid is not accepted.
- rst_n pulsed low mid-SHIFT: all outputs return to reset values asynchronously, and no out_valid appears afterwards.
- With SIMD_SEQ_ARITH_EN: O mode, right, arith, amount 2, in_data 16'h8040 gives out_data 16'hE010.
